// File: rtl/note_sequencer.sv
// note_sequencer: walks an external x/y/id ROM table, absorbing the ROM read latency,
// and presents one entry per valid/ready handshake with optional looping and paced advance.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | ROM read in flight, latency counter running down
// PRESENT | entry held on out_* until the consumer accepts it
// GAP     | auto-advance pause of tick_period cycles before the next fetch
module note_sequencer #(
    parameter int AW      = 4,
    parameter int XW      = 8,
    parameter int YW      = 8,
    parameter int IDW     = 2,
    parameter int ROM_LAT = 1,
    parameter int TW      = 26
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [AW:0]    count,
    input  logic           loop,
    input  logic           auto_en,
    input  logic [TW-1:0]  tick_period,
    output logic [AW-1:0]  rom_addr,
    input  logic [XW-1:0]  rom_x,
    input  logic [YW-1:0]  rom_y,
    input  logic [IDW-1:0] rom_id,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [XW-1:0]  out_x,
    output logic [YW-1:0]  out_y,
    output logic [IDW-1:0] out_id,
    output logic [AW-1:0]  out_idx,
    output logic           busy,
    output logic           done,
    output logic           wrap
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_GAP} state_t;

    localparam logic [AW:0]   DEPTH_V  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   IDX_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [1:0]    LAT_INIT = 2'(ROM_LAT);
    localparam logic [TW-1:0] GAP_ONE  = {{(TW-1){1'b0}}, 1'b1};

    state_t        state;
    state_t        state_next;
    logic [AW:0]   index;
    logic [AW:0]   index_adv;
    logic [AW:0]   count_q;
    logic          auto_q;
    logic [TW-1:0] period_q;
    logic [TW-1:0] gap_cnt;
    logic [1:0]    lat_cnt;
    logic          hs;
    logic          last;
    logic          gap_go;

    // Index is one bit wider than the address so count == DEPTH compares cleanly.
    assign hs        = (state == S_PRESENT) && out_valid && out_ready;
    assign last      = (index == (count_q - IDX_ONE));
    assign index_adv = last ? '0 : (index + IDX_ONE);
    assign gap_go    = auto_q && (period_q != '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start && (count != '0)) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (lat_cnt == '0) state_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (hs) begin
                    if (last && !loop) state_next = S_IDLE;
                    else if (gap_go)   state_next = S_GAP;
                    else               state_next = S_FETCH;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) state_next = S_FETCH;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rom_addr  <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_id    <= '0;
            out_idx   <= '0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            index     <= '0;
            count_q   <= '0;
            auto_q    <= 1'b0;
            period_q  <= '0;
            gap_cnt   <= '0;
            lat_cnt   <= '0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            count_q  <= (count > DEPTH_V) ? DEPTH_V : count;
                            auto_q   <= auto_en;
                            period_q <= tick_period;
                            index    <= '0;
                            rom_addr <= '0;
                            lat_cnt  <= LAT_INIT;
                        end
                    end
                end
                S_FETCH: begin
                    if (lat_cnt == '0) begin
                        out_x     <= rom_x;
                        out_y     <= rom_y;
                        out_id    <= rom_id;
                        out_idx   <= index[AW-1:0];
                        out_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                S_PRESENT: begin
                    if (hs) begin
                        out_valid <= 1'b0;
                        if (last && !loop) begin
                            done <= 1'b1;
                        end else begin
                            index <= index_adv;
                            wrap  <= last;
                            if (gap_go) begin
                                gap_cnt <= period_q - GAP_ONE;
                            end else begin
                                rom_addr <= index_adv[AW-1:0];
                                lat_cnt  <= LAT_INIT;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        rom_addr <= index[AW-1:0];
                        lat_cnt  <= LAT_INIT;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: ROM models with latency 1 and 2, expected entries queued at
// start and popped at each observed handshake.
module tb_note_sequencer;
    localparam int AW   = 4;
    localparam int TW   = 26;
    localparam int LAT1 = 1;
    localparam int LAT2 = 2;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [1:0] id;
        logic [3:0] idx;
    } ent_t;

    logic          clock = 1'b0;
    logic          reset, start, start2, loop, auto_en, out_ready, out_ready2;
    logic [AW:0]   count;
    logic [TW-1:0] tick_period;
    logic [3:0]    rom_addr, rom_addr2, out_idx, out_idx2;
    logic [7:0]    rom_x, rom_y, rom_x2, rom_y2, out_x, out_y, out_x2, out_y2;
    logic [1:0]    rom_id, rom_id2, out_id, out_id2;
    logic          out_valid, busy, done, wrap, out_valid2, busy2, done2, wrap2;

    ent_t rom_e, rom_p2, rom_e2;
    ent_t exp_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_cnt = 0, wrap_cnt = 0, rise_cnt = 0, stab_viol = 0;
    logic pv, pr;
    ent_t pd;

    note_sequencer #(.ROM_LAT(LAT1)) dut (
        .clock(clock), .reset(reset), .start(start), .count(count), .loop(loop),
        .auto_en(auto_en), .tick_period(tick_period), .rom_addr(rom_addr),
        .rom_x(rom_x), .rom_y(rom_y), .rom_id(rom_id), .out_valid(out_valid),
        .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_id(out_id),
        .out_idx(out_idx), .busy(busy), .done(done), .wrap(wrap)
    );

    note_sequencer #(.ROM_LAT(LAT2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .count(count), .loop(loop),
        .auto_en(auto_en), .tick_period(tick_period), .rom_addr(rom_addr2),
        .rom_x(rom_x2), .rom_y(rom_y2), .rom_id(rom_id2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_x(out_x2), .out_y(out_y2), .out_id(out_id2),
        .out_idx(out_idx2), .busy(busy2), .done(done2), .wrap(wrap2)
    );

    always #5 clock = ~clock;

    function automatic ent_t model(int i);
        ent_t e;
        e.x   = 8'(i * 10);
        e.y   = 8'(i + 1);
        e.id  = 2'(i % 4);
        e.idx = 4'(i);
        return e;
    endfunction

    function automatic ent_t cur_out();
        return {out_x, out_y, out_id, out_idx};
    endfunction

    function automatic ent_t cur_out2();
        return {out_x2, out_y2, out_id2, out_idx2};
    endfunction

    // External synchronous ROMs
    always @(posedge clock) begin
        rom_e  <= model(int'(rom_addr));
        rom_p2 <= model(int'(rom_addr2));
        rom_e2 <= rom_p2;
    end
    assign rom_x  = rom_e.x;
    assign rom_y  = rom_e.y;
    assign rom_id = rom_e.id;
    assign rom_x2  = rom_e2.x;
    assign rom_y2  = rom_e2.y;
    assign rom_id2 = rom_e2.id;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (pv && !pr && out_valid && (cur_out() !== pd)) stab_viol <= stab_viol + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (wrap) wrap_cnt <= wrap_cnt + 1;
        if (out_valid && !pv) rise_cnt <= rise_cnt + 1;
        pv <= out_valid;
        pr <= out_ready;
        pd <= cur_out();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic do_start(input logic [AW:0] c, input logic lp, input logic ae,
                            input logic [TW-1:0] tp, output int e0);
        count = c;
        loop = lp;
        auto_en = ae;
        tick_period = tp;
        start = 1'b1;
        e0 = cyc + 1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_hs(output bit ok, output ent_t got, output int edge_n);
        ok = 1'b0;
        got = '0;
        edge_n = -1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (out_valid && out_ready) begin
                got = cur_out();
                edge_n = cyc + 1;
                ok = 1'b1;
            end
            @(negedge clock);
        end
    endtask

    task automatic wait_valid(input bit second, output int n);
        n = 0;
        while (!(second ? out_valid2 : out_valid) && n < 100) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic pop_exp(output ent_t e);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = '1;
    endtask

    task automatic test_reset();
        n_tests++;
        if (out_valid !== 1'b0 || out_valid2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b/%b want 0/0", out_valid, out_valid2);
        end
        n_tests++;
        if ({out_x, out_y, out_id, out_idx} !== 22'd0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", cur_out());
        end
        n_tests++;
        if ({rom_addr, busy, done, wrap} !== 7'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got addr=%0d busy=%b done=%b wrap=%b want all 0",
                               rom_addr, busy, done, wrap);
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_tests++;
        if ({out_valid, busy, done} !== 3'd0) begin
            n_fail++; $display("FAIL reset_idle: got valid=%b busy=%b done=%b want 0", out_valid, busy, done);
        end
    endtask

    task automatic test_basic();
        bit ok; ent_t got, exp; int e0, edge_n, prev, d0, r0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(model(i));
        d0 = done_cnt; r0 = rise_cnt;
        out_ready = 1'b1;
        do_start(5'd4, 1'b0, 1'b0, '0, e0);
        prev = e0;
        for (int k = 0; k < 4; k++) begin
            wait_hs(ok, got, edge_n);
            pop_exp(exp);
            n_tests++;
            if (!ok || got !== exp) begin
                n_fail++; $display("FAIL basic_entry%0d: got %h want %h (seen=%0d)", k, got, exp, ok);
            end
            n_tests++;
            if (edge_n - prev !== LAT1 + 2) begin
                n_fail++; $display("FAIL basic_spacing%0d: got %0d cycles want %0d", k, edge_n - prev, LAT1 + 2);
            end
            prev = edge_n;
        end
        n_tests++;
        if ({done, busy, wrap} !== 3'b100) begin
            n_fail++; $display("FAIL basic_end: got done=%b busy=%b wrap=%b want 1 0 0", done, busy, wrap);
        end
        repeat (2) @(negedge clock);
        n_tests++;
        if (done_cnt - d0 !== 1 || rise_cnt - r0 !== 4) begin
            n_fail++; $display("FAIL basic_counts: got done=%0d rises=%0d want 1 4", done_cnt - d0, rise_cnt - r0);
        end
    endtask

    task automatic test_backpressure();
        bit ok; ent_t got, exp; int e0, edge_n, n, d0, r0, s0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(model(i));
        d0 = done_cnt; r0 = rise_cnt; s0 = stab_viol;
        out_ready = 1'b1;
        do_start(5'd4, 1'b0, 1'b0, '0, e0);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                out_ready = 1'b0;
                wait_valid(1'b0, n);
                for (int c = 0; c < 5; c++) begin
                    n_tests++;
                    if ({out_valid, out_x, out_idx} !== {1'b1, 8'd10, 4'd1}) begin
                        n_fail++; $display("FAIL bp_hold%0d: got valid=%b x=%0d idx=%0d want 1 10 1",
                                           c, out_valid, out_x, out_idx);
                    end
                    @(negedge clock);
                end
                out_ready = 1'b1;
            end
            wait_hs(ok, got, edge_n);
            pop_exp(exp);
            n_tests++;
            if (!ok || got !== exp) begin
                n_fail++; $display("FAIL bp_entry%0d: got %h want %h (seen=%0d)", k, got, exp, ok);
            end
        end
        repeat (2) @(negedge clock);
        n_tests++;
        if (done_cnt - d0 !== 1 || rise_cnt - r0 !== 4 || stab_viol - s0 !== 0) begin
            n_fail++; $display("FAIL bp_counts: got done=%0d rises=%0d unstable=%0d want 1 4 0",
                               done_cnt - d0, rise_cnt - r0, stab_viol - s0);
        end
    endtask

    task automatic test_loop();
        bit ok; ent_t got, exp; int e0, edge_n, d0, w0;
        logic [1:0] want;
        exp_q.delete();
        for (int i = 0; i < 9; i++) exp_q.push_back(model(i % 3));
        d0 = done_cnt; w0 = wrap_cnt;
        out_ready = 1'b1;
        do_start(5'd3, 1'b1, 1'b0, '0, e0);
        for (int k = 0; k < 9; k++) begin
            loop = (k != 8);
            wait_hs(ok, got, edge_n);
            pop_exp(exp);
            n_tests++;
            if (!ok || got !== exp) begin
                n_fail++; $display("FAIL loop_entry%0d: got %h want %h (seen=%0d)", k, got, exp, ok);
            end
            want = {(k == 8), ((k % 3 == 2) && (k != 8))};
            n_tests++;
            if ({done, wrap} !== want) begin
                n_fail++; $display("FAIL loop_pulse%0d: got done/wrap=%b want %b", k, {done, wrap}, want);
            end
        end
        repeat (2) @(negedge clock);
        n_tests++;
        if (done_cnt - d0 !== 1 || wrap_cnt - w0 !== 2 || busy !== 1'b0) begin
            n_fail++; $display("FAIL loop_counts: got done=%0d wraps=%0d busy=%b want 1 2 0",
                               done_cnt - d0, wrap_cnt - w0, busy);
        end
        loop = 1'b0;
    endtask

    task automatic test_auto();
        bit ok; ent_t got, exp; int e0, edge_n, n;
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(model(i));
        out_ready = 1'b1;
        do_start(5'd3, 1'b0, 1'b1, 26'd5, e0);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                repeat (5 - 1) @(negedge clock);
                n_tests++;
                if (rom_addr !== 4'd0) begin
                    n_fail++; $display("FAIL auto_addr_hold: got %0d want 0", rom_addr);
                end
                @(negedge clock);
                n_tests++;
                if (rom_addr !== 4'd1) begin
                    n_fail++; $display("FAIL auto_addr_step: got %0d want 1", rom_addr);
                end
                repeat (LAT1) @(negedge clock);
                n_tests++;
                if (out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL auto_valid_early: got %b want 0", out_valid);
                end
                @(negedge clock);
                n_tests++;
                if (out_valid !== 1'b1) begin
                    n_fail++; $display("FAIL auto_valid_rise: got %b want 1", out_valid);
                end
            end else if (k == 2) begin
                wait_valid(1'b0, n);
                n_tests++;
                if (n !== 5 + LAT1 + 1) begin
                    n_fail++; $display("FAIL auto_lag: got %0d want %0d", n, 5 + LAT1 + 1);
                end
            end
            wait_hs(ok, got, edge_n);
            pop_exp(exp);
            n_tests++;
            if (!ok || got !== exp) begin
                n_fail++; $display("FAIL auto_entry%0d: got %h want %h (seen=%0d)", k, got, exp, ok);
            end
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL auto_done: got %b want 1", done);
        end
        exp_q.delete();
        for (int i = 0; i < 2; i++) exp_q.push_back(model(i));
        do_start(5'd2, 1'b0, 1'b1, 26'd0, e0);
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                wait_valid(1'b0, n);
                n_tests++;
                if (n !== LAT1 + 1) begin
                    n_fail++; $display("FAIL auto_zero_lag: got %0d want %0d", n, LAT1 + 1);
                end
            end
            wait_hs(ok, got, edge_n);
            pop_exp(exp);
            n_tests++;
            if (!ok || got !== exp) begin
                n_fail++; $display("FAIL auto_zero_entry%0d: got %h want %h (seen=%0d)", k, got, exp, ok);
            end
        end
        auto_en = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_count_zero();
        int e0, d0, r0;
        d0 = done_cnt; r0 = rise_cnt;
        do_start(5'd0, 1'b0, 1'b0, '0, e0);
        n_tests++;
        if ({done, busy, out_valid} !== 3'b100) begin
            n_fail++; $display("FAIL zero_pulse: got done=%b busy=%b valid=%b want 1 0 0", done, busy, out_valid);
        end
        repeat (5) @(negedge clock);
        n_tests++;
        if (done_cnt - d0 !== 1 || rise_cnt - r0 !== 0) begin
            n_fail++; $display("FAIL zero_counts: got done=%0d rises=%0d want 1 0", done_cnt - d0, rise_cnt - r0);
        end
    endtask

    task automatic test_count_clamp();
        bit ok; ent_t got, exp; int e0, edge_n, d0, r0, bad;
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(model(i));
        d0 = done_cnt; r0 = rise_cnt; bad = 0;
        out_ready = 1'b1;
        do_start(5'd31, 1'b0, 1'b0, '0, e0);
        for (int k = 0; k < 16; k++) begin
            wait_hs(ok, got, edge_n);
            pop_exp(exp);
            if (!ok || got !== exp) begin
                if (bad == 0) $display("FAIL clamp_entry%0d: got %h want %h (seen=%0d)", k, got, exp, ok);
                bad++;
            end
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL clamp_entries: got %0d wrong entries want 0", bad);
        end
        repeat (4) @(negedge clock);
        n_tests++;
        if (done_cnt - d0 !== 1 || rise_cnt - r0 !== 16) begin
            n_fail++; $display("FAIL clamp_counts: got done=%0d rises=%0d want 1 16", done_cnt - d0, rise_cnt - r0);
        end
    endtask

    task automatic test_rom_lat2();
        ent_t exp; int n;
        exp_q.delete();
        for (int i = 0; i < 2; i++) exp_q.push_back(model(i));
        out_ready2 = 1'b0;
        count = 5'd2; loop = 1'b0; auto_en = 1'b0;
        start2 = 1'b1;
        @(negedge clock);
        start2 = 1'b0;
        repeat (LAT2) @(negedge clock);
        n_tests++;
        if (out_valid2 !== 1'b0) begin
            n_fail++; $display("FAIL lat2_early: got %b want 0", out_valid2);
        end
        @(negedge clock);
        pop_exp(exp);
        n_tests++;
        if (out_valid2 !== 1'b1 || cur_out2() !== exp) begin
            n_fail++; $display("FAIL lat2_first: got valid=%b %h want 1 %h", out_valid2, cur_out2(), exp);
        end
        out_ready2 = 1'b1;
        @(negedge clock);
        wait_valid(1'b1, n);
        pop_exp(exp);
        n_tests++;
        if (n !== LAT2 + 1 || cur_out2() !== exp) begin
            n_fail++; $display("FAIL lat2_second: got lag=%0d %h want %0d %h", n, cur_out2(), LAT2 + 1, exp);
        end
        @(negedge clock);
        n_tests++;
        if ({done2, busy2} !== 2'b10) begin
            n_fail++; $display("FAIL lat2_done: got done=%b busy=%b want 1 0", done2, busy2);
        end
        out_ready2 = 1'b0;
    endtask

    task automatic test_start_busy();
        bit ok; ent_t got, exp; int e0, edge_n, n, d0, r0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(model(i));
        d0 = done_cnt; r0 = rise_cnt;
        out_ready = 1'b0;
        do_start(5'd3, 1'b0, 1'b0, '0, e0);
        count = 5'd1;
        start = 1'b1;
        wait_valid(1'b0, n);
        repeat (3) @(negedge clock);
        n_tests++;
        if ({out_valid, out_idx} !== {1'b1, 4'd0}) begin
            n_fail++; $display("FAIL busy_start_hold: got valid=%b idx=%0d want 1 0", out_valid, out_idx);
        end
        start = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_hs(ok, got, edge_n);
            pop_exp(exp);
            n_tests++;
            if (!ok || got !== exp) begin
                n_fail++; $display("FAIL busy_entry%0d: got %h want %h (seen=%0d)", k, got, exp, ok);
            end
        end
        repeat (2) @(negedge clock);
        n_tests++;
        if (done_cnt - d0 !== 1 || rise_cnt - r0 !== 3) begin
            n_fail++; $display("FAIL busy_counts: got done=%0d rises=%0d want 1 3", done_cnt - d0, rise_cnt - r0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok; ent_t got, exp; int e0, edge_n, n;
        exp_q.delete();
        exp_q.push_back(model(0));
        out_ready = 1'b1;
        do_start(5'd4, 1'b0, 1'b0, '0, e0);
        wait_hs(ok, got, edge_n);
        pop_exp(exp);
        out_ready = 1'b0;
        wait_valid(1'b0, n);
        n_tests++;
        if ({out_valid, out_idx, rom_addr} !== {1'b1, 4'd1, 4'd1}) begin
            n_fail++; $display("FAIL rst_present_pre: got valid=%b idx=%0d addr=%0d want 1 1 1",
                               out_valid, out_idx, rom_addr);
        end
        reset = 1'b0;
        @(negedge clock);
        n_tests++;
        if ({out_valid, out_x, out_y, out_id, out_idx, rom_addr, busy, done, wrap} !== 30'd0) begin
            n_fail++; $display("FAIL rst_present: got valid=%b data=%h addr=%0d busy=%b want all 0",
                               out_valid, cur_out(), rom_addr, busy);
        end
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 2; i++) exp_q.push_back(model(i));
        out_ready = 1'b1;
        do_start(5'd2, 1'b0, 1'b0, '0, e0);
        for (int k = 0; k < 2; k++) begin
            wait_hs(ok, got, edge_n);
            pop_exp(exp);
            n_tests++;
            if (!ok || got !== exp) begin
                n_fail++; $display("FAIL rst_replay%0d: got %h want %h (seen=%0d)", k, got, exp, ok);
            end
        end
        @(negedge clock);
        exp_q.delete();
        exp_q.push_back(model(0));
        do_start(5'd3, 1'b0, 1'b1, 26'd10, e0);
        wait_hs(ok, got, edge_n);
        pop_exp(exp);
        repeat (2) @(negedge clock);
        n_tests++;
        if ({busy, out_valid} !== 2'b10) begin
            n_fail++; $display("FAIL rst_gap_pre: got busy=%b valid=%b want 1 0", busy, out_valid);
        end
        reset = 1'b0;
        @(negedge clock);
        n_tests++;
        if ({out_valid, out_x, out_y, out_id, out_idx, rom_addr, busy, done, wrap} !== 30'd0) begin
            n_fail++; $display("FAIL rst_gap: got valid=%b data=%h addr=%0d busy=%b want all 0",
                               out_valid, cur_out(), rom_addr, busy);
        end
        reset = 1'b1;
        exp_q.delete();
        exp_q.push_back(model(0));
        do_start(5'd1, 1'b0, 1'b0, '0, e0);
        wait_hs(ok, got, edge_n);
        pop_exp(exp);
        n_tests++;
        if (!ok || got !== exp || done !== 1'b1) begin
            n_fail++; $display("FAIL rst_gap_replay: got %h done=%b want %h done=1", got, done, exp);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; start2 = 1'b0; count = '0; loop = 1'b0;
        auto_en = 1'b0; tick_period = '0; out_ready = 1'b0; out_ready2 = 1'b0;
        repeat (3) @(negedge clock);
        test_reset();
        test_basic();
        test_backpressure();
        test_loop();
        test_auto();
        test_count_zero();
        test_count_clamp();
        test_rom_lat2();
        test_start_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
